// File: rtl/act_packer_pkg.sv
// ============================================================================
// Module : act_packer_pkg
// Brief  : Shared defaults, group-word width formula and packer state encoding.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package act_packer_pkg;

    localparam int DEF_GROUP_SIZE   = 4;
    localparam int DEF_DATA_WIDTH   = 8;
    localparam int DEF_LOG_MAX_ACTS = 24;

    // Same formula the dispatcher uses for its activation input width.
    function automatic int group_word_width(input int group_size, input int data_width);
        return group_size * data_width + group_size;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PACK  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/act_packer_if.sv
// ============================================================================
// Module : act_packer_if
// Brief  : Activation stream in, packed group stream out (valid/avail).
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface act_packer_if
    import act_packer_pkg::*;
#(
    parameter int GROUP_SIZE = DEF_GROUP_SIZE,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
    localparam int OUTPUT_WIDTH = group_word_width(GROUP_SIZE, DATA_WIDTH);

    logic [DATA_WIDTH-1:0]   data_in;
    logic                    valid_in;
    logic                    avail_out;
    logic [OUTPUT_WIDTH-1:0] data_out;
    logic                    valid_out;
    logic                    avail_in;

    modport master (
        input  data_in, valid_in, avail_in,
        output avail_out, data_out, valid_out
    );

    modport slave (
        output data_in, valid_in, avail_in,
        input  avail_out, data_out, valid_out
    );

endinterface

`default_nettype wire

// File: rtl/act_packer_fifo.sv
// ============================================================================
// Module : act_packer_fifo
// Brief  : Small circular FIFO; head is readable combinationally when non-empty.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module act_packer_fifo #(
    parameter int NUM_SLOTS     = 4,
    parameter int LOG_NUM_SLOTS = 2,
    parameter int DATA_WIDTH    = 8
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic                  wr_en,
    input  wire logic [DATA_WIDTH-1:0] wr_data,
    input  wire logic                  rd_en,
    output logic      [DATA_WIDTH-1:0] rd_data,
    output logic                       empty,
    output logic                       full,
    output logic                       almost_full
);
    localparam int CW = LOG_NUM_SLOTS + 1;

    logic [DATA_WIDTH-1:0]    r_mem [NUM_SLOTS];
    logic [LOG_NUM_SLOTS-1:0] r_wr_ptr;
    logic [LOG_NUM_SLOTS-1:0] r_rd_ptr;
    logic [CW-1:0]            r_count;
    logic                     w_wr;
    logic                     w_rd;

    // Writes while full are dropped rather than corrupting the head.
    assign w_wr        = wr_en & ~full;
    assign w_rd        = rd_en & ~empty;
    assign empty       = (r_count == '0);
    assign full        = (r_count == CW'(NUM_SLOTS));
    assign almost_full = (r_count == CW'(NUM_SLOTS - 1));
    assign rd_data     = r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) r_mem[i] <= '0;
        end else begin
            if (w_wr) begin
                r_mem[r_wr_ptr] <= wr_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/act_packer.sv
// ============================================================================
// Module : act_packer
// Brief  : Packs GROUP_SIZE activations per word with a per-lane zero mask.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module act_packer
    import act_packer_pkg::*;
#(
    parameter int GROUP_SIZE   = DEF_GROUP_SIZE,
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int LOG_MAX_ACTS = DEF_LOG_MAX_ACTS
) (
    input  wire logic                    clk,
    input  wire logic                    rst,
    input  wire logic                    configure,
    input  wire logic [LOG_MAX_ACTS-1:0] num_acts,
    output logic                         busy,
    output logic                         done,
    act_packer_if.master                 bus
);
    localparam int OUTPUT_WIDTH = group_word_width(GROUP_SIZE, DATA_WIDTH);
    localparam int LANE_W       = (GROUP_SIZE > 1) ? $clog2(GROUP_SIZE) : 1;

    state_t                  r_state;
    state_t                  w_next_state;
    logic [LOG_MAX_ACTS-1:0] r_remaining;
    logic [LANE_W-1:0]       r_lane;
    logic [DATA_WIDTH-1:0]   r_pack [GROUP_SIZE];
    logic                    r_out_full;
    logic [OUTPUT_WIDTH-1:0] r_out_data;
    logic [DATA_WIDTH-1:0]   w_head;
    logic                    w_empty;
    logic                    w_full;
    logic                    w_almost_full;
    logic                    w_xfer;
    logic                    w_completes;
    logic                    w_pop;
    logic [OUTPUT_WIDTH-1:0] w_group;

    act_packer_fifo #(
        .NUM_SLOTS     (4),
        .LOG_NUM_SLOTS (2),
        .DATA_WIDTH    (DATA_WIDTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (bus.valid_in),
        .wr_data     (bus.data_in),
        .rd_en       (w_pop),
        .rd_data     (w_head),
        .empty       (w_empty),
        .full        (w_full),
        .almost_full (w_almost_full)
    );

    assign bus.avail_out = ~w_almost_full & ~w_full;
    assign bus.valid_out = r_out_full & bus.avail_in;
    assign bus.data_out  = r_out_data;

    assign w_xfer      = r_out_full & bus.avail_in;
    assign w_completes = (r_lane == LANE_W'(GROUP_SIZE - 1)) || (r_remaining == LOG_MAX_ACTS'(1));
    // A completing pop may proceed only if the output slot frees up this cycle.
    assign w_pop = (r_state == ST_PACK) && !w_empty && (r_remaining != '0)
                   && !(w_completes && r_out_full && !w_xfer);

    // Lanes already buffered, the head on the current lane, zero beyond it.
    generate
        for (genvar j = 0; j < GROUP_SIZE; j++) begin : g_lane
            logic [DATA_WIDTH-1:0] w_lane_val;
            assign w_lane_val = (LANE_W'(j) < r_lane)  ? r_pack[j] :
                                (LANE_W'(j) == r_lane) ? w_head    : '0;
            assign w_group[j*DATA_WIDTH +: DATA_WIDTH]  = w_lane_val;
            assign w_group[GROUP_SIZE*DATA_WIDTH + j]   = (w_lane_val == '0);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (configure)
                    w_next_state = (num_acts == '0) ? ST_DRAIN : ST_PACK;
            end
            ST_PACK: begin
                busy = 1'b1;
                if (w_pop && (r_remaining == LOG_MAX_ACTS'(1)))
                    w_next_state = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!r_out_full) begin
                    done         = 1'b1;
                    w_next_state = ST_IDLE;
                end else begin
                    busy = 1'b1;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_remaining <= '0;
            r_lane      <= '0;
            r_out_full  <= 1'b0;
            r_out_data  <= '0;
            for (int i = 0; i < GROUP_SIZE; i++) r_pack[i] <= '0;
        end else begin
            if ((r_state == ST_IDLE) && configure) begin
                r_remaining <= num_acts;
                r_lane      <= '0;
            end
            if (w_pop) begin
                r_remaining <= r_remaining - 1'b1;
                if (w_completes) begin
                    r_lane <= '0;
                end else begin
                    r_pack[r_lane] <= w_head;
                    r_lane         <= r_lane + 1'b1;
                end
            end
            if (w_pop && w_completes) begin
                r_out_full <= 1'b1;
                r_out_data <= w_group;
            end else if (w_xfer) begin
                r_out_full <= 1'b0;
                r_out_data <= '0;
            end
        end
    end

endmodule

`default_nettype wire

// File: doc/act_packer.md
# act_packer

Upstream neighbour of the dispatcher. Accepts a stream of single activations, packs GROUP_SIZE consecutive activations into one group word and computes the per-lane zero mask. Emits the group on a valid/avail interface whose format is exactly the dispatcher's activation input (lanes plus ZERO_INFO bits). The number of activations per run is set by a configure pulse; a final partial group is zero-padded.

## Interface
- GROUP_SIZE, 4, lanes per group
- DATA_WIDTH, 8, activation width
- LOG_MAX_ACTS, 24, width of the activation-count register
- OUTPUT_WIDTH (localparam), GROUP_SIZE*DATA_WIDTH + GROUP_SIZE, group word width
- clk  in  1  single clock, rising edge
- rst  in  1  reset; asynchronous, active-low
- configure  in  1  start-of-run pulse; sampled only in IDLE
- num_acts  in  LOG_MAX_ACTS  activations in this run; sampled with configure
- data_in  in  DATA_WIDTH  activation
- valid_in  in  1  write data_in this cycle
- avail_out  out  1  upstream may write next cycle
- data_out  out  OUTPUT_WIDTH  lane j at [j*DATA_WIDTH +: DATA_WIDTH]; mask bit j at [GROUP_SIZE*DATA_WIDTH + j]
- valid_out  out  1  group transferred this cycle
- avail_in  in  1  downstream can accept
- busy  out  1  run in progress
- done  out  1  one-cycle pulse when the run's last group has been transferred

## Operation
- Input FIFO: 4 slots. avail_out = ~almost_full & ~full. A write while full is dropped, and the upstream contract forbids it.
- States: IDLE, PACK, DRAIN.
- IDLE: if configure is high, load remaining ← num_acts and lane ← 0.
  - If num_acts==0, go to DRAIN directly; done pulses on the next cycle.
  - Otherwise go to PACK and set busy=1.
  - FIFO contents are not popped in IDLE.
- PACK: pop one activation per cycle when the FIFO is non-empty and the pop is not blocked.
  - The popped value goes to pack lane `lane`; lane increments and remaining decrements.
  - A pop is blocked only when it would complete a group (lane==GROUP_SIZE-1 or remaining==1) while the output register is full and not being transferred this cycle.
- Group completion: the pack buffer moves to the output register, and lane resets to 0.
  - Lanes beyond the last activation are written 0.
  - Mask bit j = 1 iff lane j equals 0, padding lanes included.
  - If remaining reaches 0, go to DRAIN.
- DRAIN: wait until the output register is empty, then pulse done for one cycle, clear busy and return to IDLE.
- Output: valid_out = out_full & avail_in; the transfer happens on that cycle. data_out always shows the output register (0 when empty).
- configure outside IDLE is ignored. Activations beyond num_acts stay in the FIFO for the next run.
- Every register resets asynchronously, mid-run included: FIFO empty, state IDLE, lane 0, remaining 0, output register empty.

## Timing
- Reset values: valid_out 0, data_out 0, avail_out 1, busy 0, done 0.
- Throughput: one activation per cycle, i.e. one group every GROUP_SIZE cycles, with no bubble between groups while avail_in stays high.
- Latency: when PACK is active and the first lane is written at cycle t, the FIFO head is visible at t+1. The group is then in the output register, with valid_out possible, at t+GROUP_SIZE+1.
- The pop that completes a group and the transfer of the previous group may occur in the same cycle.
- done is asserted the cycle after the final transfer; busy falls in the same cycle as done.
- Counter arithmetic is unsigned. remaining never underflows, because pops stop at 0.

## Structure
- Shared package: default GROUP_SIZE/DATA_WIDTH, the OUTPUT_WIDTH formula (shared with the dispatcher's INPUT_WIDTH), and the state encoding.
- Sub-module: the existing FIFO (NUM_SLOTS 4, LOG_NUM_SLOTS 2, DATA_WIDTH). Packing, mask and FSM stay in this block.

## Test plan
- configure num_acts=8, data 1..8 on consecutive cycles, avail_in=1 → two groups:
  - lanes {1,2,3,4} mask 4'b0000, then {5,6,7,8} mask 4'b0000;
  - done pulses once, the cycle after the second transfer.
- num_acts=4, data 0,5,0,0 → lanes {0,5,0,0}, mask 4'b1101.
- num_acts=6, data 9..14 → {9,10,11,12} mask 4'b0000, then {13,14,0,0} mask 4'b1100.
- num_acts=16 streamed with avail_in low for 10 cycles after the first group:
  - valid_out stays low during the stall;
  - avail_out drops at almost_full;
  - all 4 groups then arrive in order with no loss or duplication.
- rst low mid-PACK after 2 pops → valid_out/busy 0 at once and FIFO empty; a fresh configure num_acts=4 with data 7,8,9,10 yields {7,8,9,10}.
- configure num_acts=0 → done pulses with no valid_out; a second configure during PACK of a num_acts=4 run is ignored and the run completes with one group.
